// File: rtl/mxrv_if_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid port, redirect input and decode handshake.
// The fetch_misalign flag exists only when MXRV_IF_MISALIGN_EN is defined.
interface mxrv_if_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef MXRV_IF_MISALIGN_EN
  logic        fetch_misalign;
`endif

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output id_valid, inst_data, inst_pc,
`ifdef MXRV_IF_MISALIGN_EN
    output fetch_misalign,
`endif
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  id_valid, inst_data, inst_pc,
`ifdef MXRV_IF_MISALIGN_EN
    input  fetch_misalign,
`endif
    output id_ready
  );
endinterface

// File: rtl/mxrv_if.sv
// mxrv instruction fetch: single-outstanding word fetch, {pc,inst} buffer towards decode, redirect flush.
// Optional MXRV_IF_MISALIGN_EN: misaligned redirect target halts fetch and raises fetch_misalign.
module mxrv_if #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  mxrv_if_if.master  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             state, state_next;
  logic [31:0]        pc, pc_next, addr, req_pc, redir_target;
  logic               drop, push, pop, gnt_hit, empty, halt_next;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic [31:0]        fifo_pc   [FIFO_DEPTH];
  logic [31:0]        fifo_inst [FIFO_DEPTH];

  assign redir_target = {bus.redirect_pc[31:2], 2'b00};
  assign empty        = (count == '0);
  // A redirect flushes the buffer, so a pop or push in that cycle is void.
  assign pop          = !empty && bus.id_ready && !bus.redirect;
  assign push         = (state == S_WAIT) && bus.imem_rvalid && !drop && !bus.redirect;
  assign gnt_hit      = (state == S_REQ) && bus.imem_gnt;

`ifdef MXRV_IF_MISALIGN_EN
  logic halted;
  assign halt_next = (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) ? 1'b1 :
                     bus.redirect ? 1'b0 : halted;

  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else     halted <= halt_next;
  end

  assign bus.fetch_misalign = halted;
`else
  logic unused_pc_lsb;
  assign halt_next     = 1'b0;
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];
`endif

  always_comb begin
    count_next = count;
    if (bus.redirect) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  // A request granted while drop is set was issued for the pre-redirect PC,
  // so pc already holds the redirect target and must not advance.
  always_comb begin
    pc_next = pc;
    if (bus.redirect)          pc_next = redir_target;
    else if (gnt_hit && !drop) pc_next = pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (!halt_next && (bus.redirect || count < DEPTH_C)) state_next = S_REQ;
      S_REQ:  if (bus.imem_gnt) state_next = S_WAIT;
      S_WAIT: if (bus.imem_rvalid)
                state_next = (!halt_next && count_next < DEPTH_C) ? S_REQ : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req  = (state == S_REQ);
    bus.imem_addr = addr;
    bus.id_valid  = !empty;
    bus.inst_data = empty ? NOP   : fifo_inst[rd_ptr];
    bus.inst_pc   = empty ? 32'h0 : fifo_pc[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      addr   <= RESET_PC;
      drop   <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      pc    <= pc_next;
      count <= count_next;
      // The address is latched on REQ entry and held until granted.
      if (state_next == S_REQ && state != S_REQ) addr <= pc_next;
      if (bus.redirect && (state == S_REQ || (state == S_WAIT && !bus.imem_rvalid)))
        drop <= 1'b1;
      else if (state == S_WAIT && bus.imem_rvalid)
        drop <= 1'b0;
      if (bus.redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_hit) req_pc <= addr;
    if (push) begin
      fifo_pc[wr_ptr]   <= req_pc;
      fifo_inst[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule
